// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               Optional feature macro: FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] u32_t;

    localparam u32_t  c_nop_instr = 32'h0000_0013;
    localparam addr_t c_reset_pc  = 64'h0000_0000_8000_0000;
    localparam addr_t c_pc_step   = 64'd4;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2,
        FAULT   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        addr_t pc;
        u32_t  raw_instr;
        logic  exc_misalign;
    } fetch_data_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction bus, redirect and decode handshake of the fetch
//               stage. if_exc_misalign exists only with
//               FETCH_MISALIGN_CHECK_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  ireq_valid;
    addr_t ireq_addr;
    logic  iresp_data_ok;
    u32_t  iresp_data;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  if_valid;
    logic  if_ready;
    addr_t if_pc;
    u32_t  if_raw_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic  if_exc_misalign;
`endif

    // Fetch stage side
    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output if_exc_misalign,
`endif
        output ireq_valid, ireq_addr, if_valid, if_pc, if_raw_instr,
        input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, if_ready
    );

    // Bus / execute / decode side
    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  if_exc_misalign,
`endif
        input  ireq_valid, ireq_addr, if_valid, if_pc, if_raw_instr,
        output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, if_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_skid_buffer
// Description : Output pipeline register plus one skid entry with valid/ready
//               handshake and flush. The producer never pushes while the skid
//               is full and the output is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_skid_buffer
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush_i,
    input  logic        in_valid_i,
    input  fetch_data_t in_data_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output fetch_data_t out_data_o
);

    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    fetch_data_t out_q, out_d;
    fetch_data_t skid_q, skid_d;

    // Next-state: flush first, then drain skid, then accept new data
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready_i) begin
                out_d        = skid_q;
                skid_valid_d = in_valid_i;
                skid_d       = in_data_i;
            end
        end else if (in_valid_i) begin
            if (!out_valid_q || out_ready_i) begin
                out_d       = in_data_i;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Register update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the fetch PC and the instruction
//               bus state machine, drops wrong-path responses after a redirect
//               and feeds decode through a register + skid buffer.
//               Optional feature macro: FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter addr_t RESET_PC  = c_reset_pc,
    parameter u32_t  NOP_INSTR = c_nop_instr
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_unit_if.master  bus
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        stale_q, stale_d;
    logic         push;
    fetch_data_t  push_data;
    logic         req_valid;
    addr_t        req_addr;
    logic         out_valid;
    fetch_data_t  out_data;
    logic         out_free;
    addr_t        redirect_target;
    logic         misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_target = bus.redirect_pc;
    assign misaligned      = (pc_q[1:0] != 2'b00);
`else
    // Low address bits are meaningless without the misalign check
    assign redirect_target = {bus.redirect_pc[63:2], 2'b00};
    assign misaligned      = 1'b0;
    logic  unused_bits;
    assign unused_bits     = ^{bus.redirect_pc[1:0], out_data.exc_misalign};
`endif

    assign out_free = !out_valid || bus.if_ready;

    // Bus state machine: next state, PC and push into the output buffer
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stale_d   = stale_q;
        push      = 1'b0;
        push_data = '{pc: pc_q, raw_instr: bus.iresp_data, exc_misalign: 1'b0};
        req_valid = 1'b0;
        req_addr  = pc_q;
        case (state_q)
            REQ: begin
                if (misaligned) begin
                    if (bus.redirect_valid) begin
                        pc_d = redirect_target;
                    end else begin
                        push                   = 1'b1;
                        push_data.raw_instr    = NOP_INSTR;
                        push_data.exc_misalign = 1'b1;
                        state_d                = FAULT;
                    end
                end else begin
                    req_valid = 1'b1;
                    if (bus.redirect_valid) begin
                        pc_d = redirect_target;
                        // A request still in flight must be drained and dropped
                        if (!bus.iresp_data_ok) begin
                            state_d = DISCARD;
                            stale_d = pc_q;
                        end
                    end else if (bus.iresp_data_ok) begin
                        push    = 1'b1;
                        pc_d    = pc_q + c_pc_step;
                        state_d = out_free ? REQ : HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (bus.if_ready) begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                req_valid = 1'b1;
                req_addr  = stale_q;
                if (bus.redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (bus.iresp_data_ok) begin
                    state_d = REQ;
                end
            end
            FAULT: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // State, PC and stale request address registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    fetch_unit_skid_buffer u_skid (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (bus.redirect_valid),
        .in_valid_i  (push),
        .in_data_i   (push_data),
        .out_ready_i (bus.if_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data)
    );

    // The request is masked while reset is held so the bus sees no request
    assign bus.ireq_valid   = req_valid && resetn;
    assign bus.ireq_addr    = req_addr;
    assign bus.if_valid     = out_valid;
    assign bus.if_pc        = out_valid ? out_data.pc : '0;
    assign bus.if_raw_instr = out_valid ? out_data.raw_instr : NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.if_exc_misalign = out_valid && out_data.exc_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed scenarios plus a
//               randomized phase checked by a scoreboard against the expected
//               in-order instruction stream.
//               Optional feature macro: FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    fetch_unit_if fif();

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (fif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h3C00_0001;
    endfunction

    function automatic logic [63:0] tgt(input logic [63:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
        return p;
`else
        return {p[63:2], 2'b00};
`endif
    endfunction

    // Reference model: the stream decode must see, in order, from the last
    // reset or redirect target; a misaligned target yields one faulting NOP.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] w;
        logic        exc;
    } exp_t;
    exp_t        sb_q[$];
    logic [63:0] gen_pc;
    logic        gen_stop;

    task automatic sb_fill();
        exp_t e;
        while (!gen_stop && sb_q.size() < 4) begin
            e.pc = gen_pc;
            if (gen_pc[1:0] != 2'b00) begin
                e.w = NOP; e.exc = 1'b1; gen_stop = 1'b1;
            end else begin
                e.w = mem_word(gen_pc); e.exc = 1'b0; gen_pc = gen_pc + 64'd4;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic sb_restart(input logic [63:0] pc);
        sb_q.delete();
        gen_pc   = pc;
        gen_stop = 1'b0;
        sb_fill();
    endtask

    // Bus model: random latency per request, data from mem_word()
    int bus_wait = -1;
    int lat_min  = 0;
    int lat_max  = 0;
    initial begin
        fif.iresp_data_ok = 1'b0;
        fif.iresp_data    = '0;
        forever begin
            @(posedge clk); #1;
            if (!resetn || !fif.ireq_valid) begin
                fif.iresp_data_ok = 1'b0;
                if (!resetn) bus_wait = -1;
            end else begin
                if (bus_wait < 0) bus_wait = $urandom_range(lat_max, lat_min);
                fif.iresp_data = mem_word(fif.ireq_addr);
                if (bus_wait == 0) begin
                    fif.iresp_data_ok = 1'b1; bus_wait = -1;
                end else begin
                    fif.iresp_data_ok = 1'b0; bus_wait--;
                end
            end
        end
    end

    // Monitor: bus protocol, flush, idle value and scoreboard pops
    logic        prev_pend  = 1'b0;
    logic        prev_redir = 1'b0;
    logic [63:0] prev_addr  = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_pend = 1'b0; prev_redir = 1'b0;
            end else begin
                if (prev_pend) begin
                    check("req_stable_valid", 64'(fif.ireq_valid), 64'd1);
                    check("req_stable_addr", fif.ireq_addr, prev_addr);
                end
                if (prev_redir) check("flush_if_valid", 64'(fif.if_valid), 64'd0);
                if (!fif.if_valid) check("idle_nop", 64'(fif.if_raw_instr), 64'(NOP));
                if (fif.if_valid && fif.if_ready && !fif.redirect_valid) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_instr", fif.if_pc, 64'hDEAD);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_pc", fif.if_pc, e.pc);
                        check("sb_instr", 64'(fif.if_raw_instr), 64'(e.w));
`ifdef FETCH_MISALIGN_CHECK_EN
                        check("sb_exc", 64'(fif.if_exc_misalign), 64'(e.exc));
`endif
                    end
                end
                prev_pend  = fif.ireq_valid && !fif.iresp_data_ok;
                prev_addr  = fif.ireq_addr;
                prev_redir = fif.redirect_valid;
            end
        end
    end

    // One cycle of stimulus; returns at the following negedge for checks
    task automatic tick(input logic rdy, input logic rd, input logic [63:0] rpc);
        @(posedge clk); #1;
        fif.if_ready       = rdy;
        fif.redirect_valid = rd;
        fif.redirect_pc    = rpc;
        if (rd) sb_restart(tgt(rpc));
        else    sb_fill();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        resetn             = 1'b0;
        fif.if_ready       = 1'b0;
        fif.redirect_valid = 1'b0;
        @(negedge clk);
        check("rst_ireq_valid", 64'(fif.ireq_valid), 64'd0);
        check("rst_if_valid", 64'(fif.if_valid), 64'd0);
        check("rst_if_pc", fif.if_pc, 64'd0);
        check("rst_raw", 64'(fif.if_raw_instr), 64'(NOP));
        @(negedge clk);
        resetn = 1'b1;
        sb_restart(RST_PC);
    endtask

    initial begin
        logic found;
        fif.if_ready       = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = '0;
        gen_pc             = RST_PC;
        gen_stop           = 1'b0;

        // Zero-latency bus, decode always ready: one instruction per cycle
        lat_min = 0; lat_max = 0;
        do_reset();
        tick(1'b1, 1'b0, '0);
        check("t1_addr0", fif.ireq_addr, RST_PC);
        check("t1_req0", 64'(fif.ireq_valid), 64'd1);
        tick(1'b1, 1'b0, '0);
        check("t1_addr1", fif.ireq_addr, RST_PC + 64'd4);
        check("t1_valid1", 64'(fif.if_valid), 64'd1);
        check("t1_pc1", fif.if_pc, RST_PC);
        check("t1_raw1", 64'(fif.if_raw_instr), 64'(mem_word(RST_PC)));
        tick(1'b1, 1'b0, '0);
        check("t1_addr2", fif.ireq_addr, RST_PC + 64'd8);
        check("t1_pc2", fif.if_pc, RST_PC + 64'd4);

        // Decode stall: second word parks in the skid, bus idles in HOLD
        do_reset();
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("t2_req_b", 64'(fif.ireq_valid), 64'd1);
        check("t2_pc_b", fif.if_pc, RST_PC);
        tick(1'b0, 1'b0, '0);
        check("t2_hold_c", 64'(fif.ireq_valid), 64'd0);
        tick(1'b0, 1'b0, '0);
        check("t2_hold_d", 64'(fif.ireq_valid), 64'd0);
        tick(1'b1, 1'b0, '0);
        check("t2_pc_e", fif.if_pc, RST_PC);
        tick(1'b1, 1'b0, '0);
        check("t2_pc_f", fif.if_pc, RST_PC + 64'd4);
        check("t2_addr_f", fif.ireq_addr, RST_PC + 64'd8);

        // Redirect while a 2-cycle request is outstanding
        lat_min = 2; lat_max = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b1, 1'b0, '0);
            found = fif.ireq_valid && (fif.ireq_addr == RST_PC + 64'd8);
        end
        check("t3_req8_seen", 64'(found), 64'd1);
        tick(1'b1, 1'b1, 64'h8000_0100);
        check("t3_no_ok_at_redirect", 64'(fif.iresp_data_ok), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick(1'b1, 1'b0, '0);
            check("t3_stale_addr", fif.ireq_addr, RST_PC + 64'd8);
            found = fif.iresp_data_ok;
        end
        check("t3_stale_done", 64'(found), 64'd1);
        tick(1'b1, 1'b0, '0);
        check("t3_new_addr", fif.ireq_addr, 64'h8000_0100);
        check("t3_if_valid", 64'(fif.if_valid), 64'd0);

        // Redirect coinciding with data_ok and a firing output
        lat_min = 0; lat_max = 0;
        do_reset();
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 64'h8000_0040);
        check("t4_pre_ok", 64'(fif.iresp_data_ok), 64'd1);
        check("t4_pre_valid", 64'(fif.if_valid), 64'd1);
        tick(1'b1, 1'b0, '0);
        check("t4_if_valid", 64'(fif.if_valid), 64'd0);
        check("t4_addr", fif.ireq_addr, 64'h8000_0040);

        // PC wrap-around at the top of the address space
        tick(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        tick(1'b1, 1'b0, '0);
        check("wrap_a", fif.ireq_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        tick(1'b1, 1'b0, '0);
        check("wrap_b", fif.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(1'b1, 1'b0, '0);
        check("wrap_c", fif.ireq_addr, 64'd0);
        tick(1'b1, 1'b0, '0);

        // Reset in the middle of an outstanding request
        lat_min = 2; lat_max = 2;
        tick(1'b1, 1'b1, 64'h8000_0800);
        tick(1'b1, 1'b0, '0);
        do_reset();
        #1;
        check("t5_addr", fif.ireq_addr, RST_PC);
        check("t5_req", 64'(fif.ireq_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, '0);
            check("t5_no_valid", 64'(fif.if_valid), 64'd0);
        end
        tick(1'b1, 1'b0, '0);
        check("t5_first_pc", fif.if_pc, RST_PC);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: no request, faulting NOP, stall until redirect
        lat_min = 0; lat_max = 0;
        tick(1'b0, 1'b1, 64'h8000_0102);
        tick(1'b0, 1'b0, '0);
        check("mis_no_req", 64'(fif.ireq_valid), 64'd0);
        tick(1'b0, 1'b0, '0);
        check("mis_valid", 64'(fif.if_valid), 64'd1);
        check("mis_exc", 64'(fif.if_exc_misalign), 64'd1);
        check("mis_raw", 64'(fif.if_raw_instr), 64'(NOP));
        check("mis_pc", fif.if_pc, 64'h8000_0102);
        check("mis_no_req2", 64'(fif.ireq_valid), 64'd0);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("mis_stall", 64'(fif.ireq_valid), 64'd0);
        tick(1'b1, 1'b1, 64'h8000_0200);
        tick(1'b1, 1'b0, '0);
        check("mis_resume", fif.ireq_addr, 64'h8000_0200);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
`endif

        // Randomized traffic: latency, stalls, redirects (some misaligned)
        lat_min = 0; lat_max = 2;
        for (int i = 0; i < 2500; i++) begin
            logic        rd;
            logic [63:0] rpc;
            rd  = ($urandom_range(19, 0) == 0);
            rpc = ($urandom_range(7, 0) == 0)
                  ? (64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(15, 0)) * 64'd4)
                  : (RST_PC + 64'($urandom_range(255, 0)) * 64'd4);
            if ($urandom_range(3, 0) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
            tick($urandom_range(9, 0) < 7, rd, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
